// File: rtl/cache_fill.sv
// Sequential cache line filler: fetches CACHE_SIZE beats from memory starting at base_addr.
// Optional CACHE_FILL_PARITY_EN adds even-parity checking of read beats (mem_rpar / par_err).
module cache_fill #(
    parameter int CACHE_SIZE     = 8,
    parameter int MEM_DATA_WIDTH = 8,
    parameter int ADDR_W         = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [ADDR_W-1:0]                          base_addr,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       mem_req,
    output logic [ADDR_W-1:0]                          mem_addr,
    input  logic                                       mem_gnt,
    input  logic                                       mem_rvalid,
    input  logic [MEM_DATA_WIDTH-1:0]                  mem_rdata,
`ifdef CACHE_FILL_PARITY_EN
    input  logic                                       mem_rpar,
    output logic                                       par_err,
`endif
    output logic [CACHE_SIZE-1:0][MEM_DATA_WIDTH-1:0]  cache_mem,
    output logic [$clog2(CACHE_SIZE)-1:0]              fill_idx
);

    localparam int IDX_W = $clog2(CACHE_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CACHE_SIZE - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] base_q;
    logic              accept_start;
    logic              beat;

    assign accept_start = (state == S_IDLE) && start;
    // rvalid only counts in WAIT, which is entered strictly after the grant edge
    assign beat         = (state == S_WAIT) && mem_rvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            base_q   <= '0;
            fill_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        fill_idx <= '0;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        if (fill_idx == LAST_IDX) begin
                            state <= S_DONE;
                        end else begin
                            fill_idx <= fill_idx + 1'b1;
                            state    <= S_REQ;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_mem <= '0;
        end else if (beat) begin
            cache_mem[fill_idx] <= mem_rdata;
        end
    end

`ifdef CACHE_FILL_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err <= 1'b0;
        end else if (accept_start) begin
            par_err <= 1'b0;
        end else if (beat && ((^mem_rdata) != mem_rpar)) begin
            par_err <= 1'b1;
        end
    end
`endif

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign mem_req  = (state == S_REQ);
    assign mem_addr = base_q + ADDR_W'(fill_idx);

endmodule

// File: tb/tb_cache_fill.sv
// Self-checking bench for cache_fill: a bench-side memory responder drives directed and random
// fills while an array model tracks expected cache contents, addresses and handshake outputs.
module tb_cache_fill;
    localparam int N  = 8;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int IW = $clog2(N);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [AW-1:0]        base_addr;
    logic                 busy;
    logic                 done;
    logic                 mem_req;
    logic [AW-1:0]        mem_addr;
    logic                 mem_gnt;
    logic                 mem_rvalid;
    logic [DW-1:0]        mem_rdata;
    logic [N-1:0][DW-1:0] cache_mem;
    logic [IW-1:0]        fill_idx;
`ifdef CACHE_FILL_PARITY_EN
    logic                 mem_rpar;
    logic                 par_err;
`endif

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model [N];
    logic          model_perr;

    always #5 clk = ~clk;

    cache_fill #(
        .CACHE_SIZE    (N),
        .MEM_DATA_WIDTH(DW),
        .ADDR_W        (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
`ifdef CACHE_FILL_PARITY_EN
        .mem_rpar  (mem_rpar),
        .par_err   (par_err),
`endif
        .cache_mem (cache_mem),
        .fill_idx  (fill_idx)
    );

    function automatic logic [N*DW-1:0] model_flat();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = model[i];
        return v;
    endfunction

    task automatic check(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic exp_busy, input logic exp_done,
                                 input logic exp_req, input logic [AW-1:0] exp_addr, input int exp_idx);
        logic [31:0] idx;
        idx = exp_idx;
        check({tag, ".busy"}, busy, exp_busy);
        check({tag, ".done"}, done, exp_done);
        check({tag, ".req"}, mem_req, exp_req);
        if (exp_req) check({tag, ".addr"}, mem_addr, exp_addr);
        if (exp_idx >= 0) check({tag, ".idx"}, fill_idx, idx[IW-1:0]);
        check({tag, ".mem"}, cache_mem, model_flat());
`ifdef CACHE_FILL_PARITY_EN
        check({tag, ".perr"}, par_err, model_perr);
`endif
    endtask

    // Noise on inputs the DUT must ignore outside IDLE / WAIT
    task automatic spur(input int mode);
        if (mode != 0) begin
            start      = 1'($urandom_range(0, 1));
            base_addr  = AW'($urandom);
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = DW'($urandom);
        end else begin
            start      = 1'b0;
            mem_rvalid = 1'b0;
        end
    endtask

    // mode 0: no stalls, data 0xA0+i; mode 1: 3-cycle grant stall on entry 2; mode 2: random stalls
    task automatic run_fill(input logic [AW-1:0] base, input int mode, input int abort_idx, input int par_idx);
        int            gd;
        int            rd;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic          rpar;
        start      = 1'b1;
        base_addr  = base;
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
        @(negedge clk);
        start      = 1'b0;
        model_perr = 1'b0;
        for (int i = 0; i < N; i++) begin
            addr = base + AW'(i);
            gd   = (mode == 1 && i == 2) ? 3 : ((mode == 2) ? int'($urandom_range(0, 3)) : 0);
            rd   = (mode == 2) ? int'($urandom_range(0, 3)) : 0;
            data = (mode == 0) ? DW'(8'hA0 + i) : DW'($urandom);
            rpar = ^data;
            if (i == par_idx) begin
                data = 8'h03;
                rpar = 1'b1;
            end
            for (int d = 0; d < gd; d++) begin
                check_outputs("req_hold", 1'b1, 1'b0, 1'b1, addr, i);
                mem_gnt = 1'b0;
                spur(mode);
                @(negedge clk);
            end
            check_outputs("req_gnt", 1'b1, 1'b0, 1'b1, addr, i);
            mem_gnt = 1'b1;
            spur(mode);
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (i == abort_idx) begin
                check_outputs("wait_pre_rst", 1'b1, 1'b0, 1'b0, addr, i);
                rst = 1'b1;
                #1;
                for (int k = 0; k < N; k++) model[k] = '0;
                model_perr = 1'b0;
                check_outputs("rst_async", 1'b0, 1'b0, 1'b0, '0, 0);
                check("rst_async.addr", mem_addr, '0);
                @(negedge clk);
                rst        = 1'b0;
                start      = 1'b0;
                mem_rvalid = 1'b1;
                mem_rdata  = DW'($urandom);
                @(negedge clk);
                check_outputs("late_rvalid", 1'b0, 1'b0, 1'b0, '0, 0);
                mem_rvalid = 1'b0;
                @(negedge clk);
                check_outputs("post_abort", 1'b0, 1'b0, 1'b0, '0, 0);
                return;
            end
            for (int d = 0; d < rd; d++) begin
                check_outputs("wait_hold", 1'b1, 1'b0, 1'b0, addr, i);
                spur(mode);
                mem_rvalid = 1'b0;
                @(negedge clk);
            end
            check_outputs("wait_beat", 1'b1, 1'b0, 1'b0, addr, i);
            spur(mode);
            mem_rvalid = 1'b1;
            mem_rdata  = data;
`ifdef CACHE_FILL_PARITY_EN
            mem_rpar = rpar;
`endif
            @(negedge clk);
            mem_rvalid = 1'b0;
            model[i]   = data;
            if ((^data) != rpar) model_perr = 1'b1;
        end
        check_outputs("done", 1'b1, 1'b1, 1'b0, '0, N - 1);
        start      = 1'b1;
        base_addr  = AW'($urandom);
        mem_rvalid = 1'b1;
        mem_rdata  = DW'($urandom);
        @(negedge clk);
        start      = 1'b0;
        mem_rvalid = 1'b0;
        check_outputs("idle_after", 1'b0, 1'b0, 1'b0, '0, -1);
        @(negedge clk);
        check_outputs("idle_hold", 1'b0, 1'b0, 1'b0, '0, -1);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
`ifdef CACHE_FILL_PARITY_EN
        mem_rpar   = 1'b0;
`endif
        for (int k = 0; k < N; k++) model[k] = '0;
        model_perr = 1'b0;

        @(negedge clk);
        check_outputs("reset", 1'b0, 1'b0, 1'b0, '0, 0);
        check("reset.addr", mem_addr, '0);
        @(negedge clk);
        rst = 1'b0;

        mem_rvalid = 1'b1;
        mem_rdata  = 8'h5A;
        @(negedge clk);
        check_outputs("idle_rvalid", 1'b0, 1'b0, 1'b0, '0, 0);
        mem_rvalid = 1'b0;
        @(negedge clk);

        run_fill(16'h0100, 0, -1, -1);
        run_fill(16'h0100, 1, -1, -1);
        run_fill(16'hFFFC, 2, -1, -1);
        run_fill(16'h2000, 0, 4, -1);
        run_fill(16'h3000, 2, -1, -1);
        for (int r = 0; r < 4; r++) run_fill(AW'($urandom), 2, -1, -1);
`ifdef CACHE_FILL_PARITY_EN
        run_fill(16'h4000, 0, -1, 5);
        run_fill(16'h5000, 2, -1, -1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
